// File: rtl/iter_div_ctrl_pkg.sv
// Shared constants and the full-adder cell used by the iterative divider.
package iter_div_ctrl_pkg;

  // Controller state encodings (kept as plain constants for legacy EX code).
  localparam logic [1:0] DIV_IDLE   = 2'b00;
  localparam logic [1:0] DIV_BYZERO = 2'b01;
  localparam logic [1:0] DIV_ON     = 2'b10;
  localparam logic [1:0] DIV_END    = 2'b11;

  // Result handshake levels, also used by the EX / HI-LO write logic.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // One-bit full adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic cin);
    fa = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: minuend - subtrahend as a ripple of full-adder
// cells (subtrahend inverted, carry-in 1). The final carry-out is 1 exactly
// when the unsigned difference is non-negative.
module div_step
  import iter_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           nonneg
);

  // Ripple the carry from bit 0 upward through the adder cells.
  always_comb begin
    logic c;
    // NOTE: every output gets a value before the loop so no latch is inferred.
    diff = '0;
    c    = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      {c, diff[i]} = fa(minuend[i], ~subtrahend[i], c);
    end
    nonneg = c;
  end

endmodule

// File: rtl/iter_div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU issued from EX.
// Works on operand magnitudes, one quotient bit per cycle, and fixes up the
// signs on the final iteration. Result is {remainder, quotient} for HI/LO.
module iter_div_ctrl
  import iter_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr;     // divisor magnitude
  logic [WIDTH-1:0] rem;     // partial remainder
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             nonneg;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quot_fix;
  logic             unused_diff_msb;

  // Magnitudes at acceptance; -0x80000000 wraps to 0x80000000, which is the
  // correct unsigned magnitude, so no extra bit is needed here.
  assign mag1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Bring down the next dividend bit and trial-subtract the divisor.
  assign rem_sh = {rem, dvd[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .minuend    (rem_sh),
    .subtrahend ({1'b0, dsr}),
    .diff       (diff),
    .nonneg     (nonneg)
  );

  // A successful subtract is always below the divisor, so its top bit is 0.
  assign unused_diff_msb = diff[WIDTH];

  assign rem_next  = nonneg ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quot_next = {dvd[WIDTH-2:0], nonneg};
  assign quot_fix  = neg_q ? -quot_next : quot_next;
  assign rem_fix   = neg_r ? -rem_next  : rem_next;

  // Controller FSM with iteration counter, datapath registers and outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start_i && !annul_i) begin
            neg_q  <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r  <= signed_i && opdata1_i[WIDTH-1];
            dvd    <= mag1;
            dsr    <= mag2;
            rem    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
          end
        end

        DIV_BYZERO: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state <= DIV_IDLE;
          end else begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_READY;
            state    <= DIV_END;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            busy_o <= 1'b0;
            state  <= DIV_IDLE;
          end else begin
            dvd <= quot_next;
            rem <= rem_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ITER) begin
              result_o <= {rem_fix, quot_fix};
              ready_o  <= DIV_RESULT_READY;
              busy_o   <= 1'b0;
              state    <= DIV_END;
            end
          end
        end

        DIV_END: begin
          if (!start_i || annul_i) begin
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
            state    <= DIV_IDLE;
          end
        end

        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_ctrl.sv
// Directed bench for iter_div_ctrl: stimulus pushes expected results into a
// queue, a negedge monitor pops one on each rising ready_o and compares.
module tb_iter_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_in;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic        ready_seen = 1'b0;

  iter_div_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .annul_i   (annul),
    .signed_i  (signed_in),
    .opdata1_i (op1),
    .opdata2_i (op2),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected result consumed per rising edge of ready_o.
  always @(negedge clk) begin
    logic [63:0] e;
    if (ready_o === 1'b1 && !ready_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(ready_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", result_o, e);
      end
    end
    ready_seen = (ready_o === 1'b1);
  end

  // Issue one divide, hold start in END for 'hold' cycles, then leave END by
  // dropping start (or by annul when by_annul is set).
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat, input int hold,
                         input logic by_annul);
    int n;
    int busy_n;
    @(negedge clk);
    start = 1'b1; annul = 1'b0; signed_in = sg; op1 = a; op2 = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    busy_n = busy_o ? 1 : 0;
    n = 0;
    // Operands changed after acceptance must be ignored.
    op1 = ~a; op2 = 32'd1; signed_in = ~sg;
    while (ready_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready_o !== 1'b1 && busy_o === 1'b1) busy_n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("busy_cycles", 64'(busy_n), 64'(exp_lat));
    check("busy_at_ready", 64'(busy_o), 64'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_result", result_o, exp);
      check("hold_ready", 64'(ready_o), 64'd1);
    end
    @(negedge clk);
    if (by_annul) annul = 1'b1;
    else          start = 1'b0;
    @(posedge clk); #1;
    check("exit_ready", 64'(ready_o), 64'd0);
    check("exit_result", result_o, 64'd0);
    check("exit_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_in = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_flags", 64'({ready_o, busy_o}), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Unsigned and signed divides, including the 2^31 magnitude corner.
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32, 5, 1'b0);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32, 1, 1'b0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 32, 1, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 32, 0, 1'b0);
    run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 32, 0, 1'b1);
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 32, 0, 1'b0);
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, 32, 0, 1'b0);
    run_div(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 32, 0, 1'b0);

    // Divide by zero: result 0, ready one edge after acceptance.
    run_div(1'b0, 32'd5, 32'd0, 64'd0, 1, 2, 1'b0);

    // Start together with annul in IDLE is not accepted.
    @(negedge clk);
    start = 1'b1; annul = 1'b1; op1 = 32'd5; op2 = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    check("start_annul_busy", 64'(busy_o), 64'd0);
    @(negedge clk); start = 1'b0; annul = 1'b0;

    // Annul at iteration 10, then an immediate new divide.
    @(negedge clk);
    start = 1'b1; signed_in = 1'b0; op1 = 32'd1000; op2 = 32'd7;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    check("annul_busy", 64'(busy_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, 1, 1'b0);

    // Reset mid-divide, then a fresh divide is accepted.
    @(negedge clk);
    start = 1'b1; signed_in = 1'b0; op1 = 32'd50; op2 = 32'd5;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("midreset_result", result_o, 64'd0);
    check("midreset_flags", 64'({ready_o, busy_o}), 64'd0);
    @(negedge clk); rst = 1'b0;
    run_div(1'b0, 32'd77, 32'd7, {32'd0, 32'd11}, 32, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
